// File: rtl/seg_capture.sv
// seg_capture: monitors a multiplexed seven-segment bus, debounces each
// {an, seg} pair, decodes stable digits back to hex nibbles and assembles
// complete 16-bit frames.
//
// Handshake: there is no backpressure. valid is a one-cycle pulse marking the
// cycle in which value holds a freshly completed, error-free frame; err is a
// one-cycle pulse marking a discarded frame. Both are registered and never
// high together.
module seg_capture #(
  parameter int STABLE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] value,
  output logic        valid,
  output logic        err,
  output logic        busy,
  output logic        fsm_state
);

  typedef enum logic {IDLE = 1'b0, COLLECT = 1'b1} state_t;

  // cnt counts edges after the first one a pair is seen, so a pair held for
  // STABLE edges is captured when cnt is about to move from STABLE-2.
  localparam logic [7:0] CAP_CNT = 8'(STABLE - 2);
  localparam logic [7:0] SAT_CNT = 8'(STABLE - 1);

  state_t      state, next_state;
  logic [10:0] prev;
  logic [7:0]  cnt;
  logic [3:0]  mask, next_mask;
  logic [15:0] shadow, next_shadow;
  logic [15:0] next_value;
  logic        next_valid, next_err;
  logic [10:0] pair;
  logic        same, capture, one_hot;
  logic [4:0]  dec;
  logic [3:0]  new_mask;

  // Maps a segment pattern to {legal, nibble}; anything not listed is illegal.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h3F: decode = {1'b1, 4'h0};
      7'h06: decode = {1'b1, 4'h1};
      7'h5B: decode = {1'b1, 4'h2};
      7'h4F: decode = {1'b1, 4'h3};
      7'h66: decode = {1'b1, 4'h4};
      7'h6D: decode = {1'b1, 4'h5};
      7'h7D: decode = {1'b1, 4'h6};
      7'h07: decode = {1'b1, 4'h7};
      7'h7F: decode = {1'b1, 4'h8};
      7'h6F: decode = {1'b1, 4'h9};
      7'h77: decode = {1'b1, 4'hA};
      7'h7C: decode = {1'b1, 4'hB};
      7'h39: decode = {1'b1, 4'hC};
      7'h5E: decode = {1'b1, 4'hD};
      7'h79: decode = {1'b1, 4'hE};
      7'h71: decode = {1'b1, 4'hF};
      default: decode = 5'b0_0000;
    endcase
  endfunction

  assign pair     = {an, seg};
  assign same     = (pair == prev);
  assign capture  = same && (cnt == CAP_CNT);
  assign one_hot  = (an != 4'b0000) && ((an & (an - 4'd1)) == 4'b0000);
  assign dec      = decode(seg);
  assign new_mask = mask | an;
  assign busy     = (mask != 4'b0000);
  assign fsm_state = state;

  // Stability filter: remember the last pair and count how long it has held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev <= '0;
      cnt  <= '0;
    end else begin
      prev <= pair;
      if (!same)
        cnt <= '0;
      else if (cnt != SAT_CNT)
        cnt <= cnt + 8'd1;
    end
  end

  // Frame state, digit mask, shadow nibbles, output word and pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      mask   <= '0;
      shadow <= '0;
      value  <= '0;
      valid  <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= next_state;
      mask   <= next_mask;
      shadow <= next_shadow;
      value  <= next_value;
      valid  <= next_valid;
      err    <= next_err;
    end
  end

  // Capture decision: blanking is ignored, bad selects or patterns discard the
  // frame, legal digits fill the shadow and the fourth distinct one completes it.
  always_comb begin
    next_state  = state;
    next_mask   = mask;
    next_shadow = shadow;
    next_value  = value;
    next_valid  = 1'b0;
    next_err    = 1'b0;
    if (capture && (an != 4'b0000)) begin
      if (!one_hot || !dec[4]) begin
        next_err   = 1'b1;
        next_mask  = 4'b0000;
        next_state = IDLE;
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (an[i]) next_shadow[i*4 +: 4] = dec[3:0];
        end
        if (new_mask == 4'hF) begin
          next_value = next_shadow;
          next_valid = 1'b1;
          next_mask  = 4'b0000;
          next_state = IDLE;
        end else begin
          next_mask  = new_mask;
          next_state = COLLECT;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_capture.sv
// Bench for seg_capture: directed scenarios plus randomized bus traffic,
// checked every cycle against a run-length based reference model.
module tb_seg_capture;

  localparam int STABLE = 4;

  logic        clk;
  logic        reset;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] value;
  logic        valid;
  logic        err;
  logic        busy;
  logic        fsm_state;

  seg_capture #(.STABLE(STABLE)) dut (
    .clk(clk), .reset(reset), .seg(seg), .an(an),
    .value(value), .valid(valid), .err(err), .busy(busy),
    .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int n_err    = 0;
  logic [15:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0]  lut[16];
  logic [10:0] m_prev;
  int          m_run;
  logic [3:0]  m_mask;
  logic [3:0]  m_shadow[4];
  logic [15:0] m_value;
  logic        m_valid, m_err;

  initial begin
    lut[0]  = 7'h3F; lut[1]  = 7'h06; lut[2]  = 7'h5B; lut[3]  = 7'h4F;
    lut[4]  = 7'h66; lut[5]  = 7'h6D; lut[6]  = 7'h7D; lut[7]  = 7'h07;
    lut[8]  = 7'h7F; lut[9]  = 7'h6F; lut[10] = 7'h77; lut[11] = 7'h7C;
    lut[12] = 7'h39; lut[13] = 7'h5E; lut[14] = 7'h79; lut[15] = 7'h71;
  end

  // Reset leaves the remembered pair at zero, which counts as already seen once.
  task automatic model_reset();
    m_prev  = '0;
    m_run   = 1;
    m_mask  = '0;
    for (int i = 0; i < 4; i++) m_shadow[i] = '0;
    m_value = '0;
    m_valid = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic model_edge(input logic [3:0] a, input logic [6:0] s);
    int   d;
    int   idx;
    logic [10:0] p;
    p = {a, s};
    if (p == m_prev) m_run++;
    else m_run = 1;
    m_prev  = p;
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (m_run == STABLE && a != 4'b0000) begin
      d = -1;
      for (int k = 0; k < 16; k++) if (lut[k] == s) d = k;
      if ($countones(a) > 1 || d < 0) begin
        m_err  = 1'b1;
        m_mask = 4'b0000;
      end else begin
        idx = 0;
        for (int i = 0; i < 4; i++) if (a[i]) idx = i;
        m_shadow[idx] = 4'(d);
        m_mask[idx]   = 1'b1;
        if (m_mask == 4'hF) begin
          m_value = {m_shadow[3], m_shadow[2], m_shadow[1], m_shadow[0]};
          m_valid = 1'b1;
          m_mask  = 4'b0000;
          exp_q.push_back(m_value);
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic [3:0] a, input logic [6:0] s);
    logic [15:0] e;
    an  = a;
    seg = s;
    @(posedge clk);
    model_edge(a, s);
    @(negedge clk);
    check_eq("valid", valid, m_valid);
    check_eq("err", err, m_err);
    check_eq("busy", busy, (m_mask != 4'b0000));
    check_eq("value", value, m_value);
    if (valid) n_valid++;
    if (err) n_err++;
    if (valid) begin
      check_eq("sb_pending", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("sb_value", value, e);
      end
    end
  endtask

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
    for (int i = 0; i < n; i++) cycle(a, s);
  endtask

  task automatic async_reset();
    reset = 1'b1;
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_value", value, 0);
    check_eq("rst_valid", valid, 0);
    check_eq("rst_err", err, 0);
    model_reset();
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int v0, e0;
    logic [3:0] ra;
    logic [6:0] rs;
    reset = 1'b1;
    an    = '0;
    seg   = '0;
    #1;
    check_eq("init_value", value, 0);
    check_eq("init_busy", busy, 0);
    check_eq("init_valid", valid, 0);
    check_eq("init_err", err, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    hold(4'b0000, 7'h00, 3);

    // Full frame 1234, each digit held 6 cycles.
    v0 = n_valid; e0 = n_err;
    hold(4'b1000, 7'h06, 6);
    hold(4'b0100, 7'h5B, 6);
    hold(4'b0010, 7'h4F, 6);
    hold(4'b0001, 7'h66, 6);
    check_eq("frame_valid_cnt", n_valid - v0, 1);
    check_eq("frame_err_cnt", n_err - e0, 0);
    check_eq("frame_value", value, 16'h1234);

    // Glitch rejection: 3-cycle hold is ignored, 4-cycle hold captures.
    hold(4'b0001, 7'h7F, 3);
    hold(4'b0000, 7'h00, 2);
    check_eq("glitch_busy", busy, 0);
    hold(4'b0001, 7'h7F, 4);
    hold(4'b0000, 7'h00, 2);
    check_eq("glitch_capture_busy", busy, 1);

    // Illegal pattern after digits 0 and 1, then an all-F frame.
    e0 = n_err;
    hold(4'b0010, lut[1], 5);
    hold(4'b0100, 7'h00, 4);
    hold(4'b0000, 7'h00, 1);
    check_eq("illegal_err_cnt", n_err - e0, 1);
    check_eq("illegal_busy", busy, 0);
    for (int i = 0; i < 4; i++) hold(4'(1 << i), 7'h71, 5);
    check_eq("allf_value", value, 16'hFFFF);

    // Illegal select, then a frame with long blanking gaps.
    e0 = n_err;
    hold(4'b0011, 7'h3F, 4);
    hold(4'b0000, 7'h00, 1);
    check_eq("sel_err_cnt", n_err - e0, 1);
    check_eq("sel_busy", busy, 0);
    e0 = n_err; v0 = n_valid;
    hold(4'b0001, lut[7], 5);  hold(4'b0000, 7'h00, 30);
    hold(4'b0100, lut[12], 5); hold(4'b0000, 7'h00, 25);
    hold(4'b1000, lut[9], 5);  hold(4'b0000, 7'h00, 40);
    hold(4'b0010, lut[3], 5);  hold(4'b0000, 7'h00, 2);
    check_eq("blank_err_cnt", n_err - e0, 0);
    check_eq("blank_valid_cnt", n_valid - v0, 1);
    check_eq("blank_value", value, 16'h9C37);

    // Overwrite digit 0: 5 then A, then digits 1..3 as 0.
    hold(4'b0001, lut[5], 5);
    hold(4'b0001, lut[10], 5);
    for (int i = 1; i < 4; i++) hold(4'(1 << i), lut[0], 5);
    check_eq("overwrite_value", value, 16'h000A);

    // Reset mid-frame after two digits; two more digits must not complete.
    hold(4'b0001, lut[6], 5);
    hold(4'b0010, lut[4], 5);
    async_reset();
    v0 = n_valid;
    hold(4'b0100, lut[2], 5);
    hold(4'b1000, lut[8], 5);
    check_eq("post_rst_valid_cnt", n_valid - v0, 0);
    check_eq("post_rst_value", value, 16'h0000);
    check_eq("post_rst_busy", busy, 1);

    // Randomized bus traffic.
    async_reset();
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: begin
          ra = 4'(1 << $urandom_range(0, 3));
          rs = lut[$urandom_range(0, 15)];
        end
        6: begin ra = 4'b0000; rs = 7'($urandom_range(0, 127)); end
        7: begin ra = 4'(1 << $urandom_range(0, 3)); rs = 7'($urandom_range(0, 127)); end
        8: begin ra = 4'($urandom_range(1, 15)); rs = lut[$urandom_range(0, 15)]; end
        default: begin ra = an; rs = seg; end
      endcase
      hold(ra, rs, $urandom_range(1, STABLE + 3));
    end
    hold(4'b0000, 7'h00, 2);
    check_eq("sb_drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_capture.md
# seg_capture

Receive-side companion to the team's hex-to-seven-segment decoder. Samples a multiplexed seven-segment bus (segment lines a..g plus four digit-select lines) and waits until each digit's pattern is stable. Maps each pattern back to its 4-bit hex value and assembles a complete 16-bit word once all four digits have been seen. Used as a loopback checker and display-bus monitor next to the display driver.

## Interface

- STABLE, 4, consecutive rising edges a {an, seg} pair must be held before it is captured; legal range 2..255
- clk  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-high; clears all state
- seg  in  7  segment lines, active-high; seg[0]=a … seg[6]=g
- an  in  4  digit select, active-high, one-hot; an[i] selects nibble i (an[0] = least significant)
- value  out  16  last complete frame; nibble i = digit i
- valid  out  1  one-cycle pulse: value updated with a complete, error-free frame
- err  out  1  one-cycle pulse: illegal pattern or illegal digit select captured
- busy  out  1  high while the current frame has at least one digit captured but is incomplete

## Operation

- Legal patterns, seg[6:0] as hex: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71. Any other pattern, including 00, is illegal.
- Stability filter:
  - Previous {an, seg} is held in a register.
  - Counter cnt clears whenever the input differs from the previous value, and increments otherwise.
  - cnt saturates, so each stable period produces at most one capture.
- Blanking: an=0000 never captures and never flags an error. It only resets the stability counter, through the normal change rule.
- Capture event, with the pair stable for STABLE edges:
  - **an not one-hot (two or more bits set):** err pulse; the frame is discarded (mask cleared, shadow kept).
  - **an one-hot, seg illegal:** err pulse; the frame is discarded.
  - **an one-hot, seg legal:** shadow nibble i gets the decoded value and mask[i] is set. A repeat capture of an already-set digit overwrites the nibble and leaves mask unchanged.
- Frame completion:
  - Triggered when a legal capture makes mask = 1111.
  - value gets the shadow contents including the new nibble, valid pulses, and mask clears in the same edge.
- Scan order is arbitrary, and gaps of any length between digits are allowed.
- busy = (mask != 0000).
- Frame state machine:
  - **IDLE** (mask=0): a legal capture → COLLECT.
  - **COLLECT**: an error → IDLE. The fourth distinct digit → IDLE, with valid.

## Timing

- Reset values: value=0000, valid=0, err=0, busy=0, mask=0000, cnt=0, previous pair=0.
- Reset acts immediately and asynchronously, including in the middle of a frame. A partial frame is lost, and no valid or err follows the release of reset.
- Define edge 1 as the first rising edge at which a new pair is present. Capture happens at edge STABLE, and valid/err are high for exactly the cycle after that edge.
- A pair held for STABLE−1 edges or fewer is never captured.
- After a change, the pair must again be held for the full STABLE edges.
- valid and err are never high in the same cycle. Back-to-back pulses are impossible (captures are at least STABLE edges apart).
- value changes only at the edge that raises valid; it holds otherwise.
- Throughput: one digit per STABLE cycles minimum; one frame per 4·STABLE cycles minimum.

## Test plan

- **Reset:** assert reset mid-frame after two digits → busy=0 and value=0000 asynchronously. After release, feed 2 more digits → no valid.
- **Full frame, STABLE=4:**
  - Stimulus: each digit held 6 cycles — an=1000 seg=06, an=0100 seg=5B, an=0010 seg=4F, an=0001 seg=66.
  - Expected: exactly one valid pulse, 4 cycles after the last digit appears; value=1234; err never high.
- **Glitch rejection:** an=0001 seg=7F held 3 cycles, then an=0000 → no capture, busy stays 0. Repeat with a 4-cycle hold → busy=1.
- **Illegal pattern:**
  - Stimulus: after digits 0 and 1 are captured, an=0100 seg=00 for 4 cycles.
  - Expected: err pulses once; busy=0; a following full frame of all-F digits (seg=71) → valid with value=FFFF.
- **Illegal select and blanking:**
  - an=0011 seg=3F for 4 cycles → err pulse, no mask bits set.
  - Long an=0000 gaps between legal digits → no err; the frame still completes.
- **Overwrite:** capture digit 0 as 5, then again as A, then digits 1..3 as 0 → valid with value=000A.
